post_norm_fmul: RTL

Multi-cycle post-normalization and rounding stage for FPU multiply and divide. It sits downstream of the multiply/divide pre-normalizer and the mantissa datapath. It accepts a 48-bit unnormalized magnitude with a biased exponent, sign and exponent range flags, then produces a packed IEEE-754 single-precision result with exception flags. Normalization shifts one bit per clock under an FSM, with valid/ready handshakes on both sides.

---
 rtl/post_norm_fmul_if.sv | 30 +++
 rtl/post_norm_fmul.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/post_norm_fmul_if.sv
// Handshake and payload bundle for the FMUL/FDIV post-normalization stage.
// The producer/consumer side uses master; the normalizer itself uses slave.
`timescale 1ns/1ps
interface post_norm_fmul_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  rmode;
  logic [47:0] fract_in;
  logic [7:0]  exp_in;
  logic [1:0]  exp_ovf;
  logic        sign_in;
  logic        inf_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;
  logic        zero;

  modport master (
    output in_valid, rmode, fract_in, exp_in, exp_ovf, sign_in, inf_in, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact, zero
  );

  modport slave (
    input  in_valid, rmode, fract_in, exp_in, exp_ovf, sign_in, inf_in, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact, zero
  );
endinterface

// File: rtl/post_norm_fmul.sv
// Post-normalization and rounding for FPU multiply/divide: one normalizing shift
// per clock, then rounding to a packed single-precision result with exception flags.
`timescale 1ns/1ps
module post_norm_fmul (
  input  logic              clk,
  input  logic              rst_n,
  post_norm_fmul_if.slave   bus
);
  localparam int unsigned FW = 48;
  localparam int unsigned EW = 10;
  localparam int unsigned RW = 32;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;
  localparam logic [30:0] MAX_MAG = 31'h7F7F_FFFF;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t        state_q, state_n;
  logic [FW-1:0] f_q, f_n;
  logic [EW-1:0] e_q, e_n;
  logic          s_q, s_n;
  logic          first_q, first_n;
  logic [1:0]    rmode_q, exp_ovf_q;
  logic          sign_q, inf_q;
  logic [RW-1:0] result_q, result_n;
  logic          ovf_q, ovf_n, unf_q, unf_n, inx_q, inx_n, zero_q, zero_n;
  logic          out_valid_q, out_valid_n, in_ready_q, in_ready_n;
  logic          accept_c;

  // Overflow saturates to infinity or max-finite depending on direction of rounding.
  function automatic logic [RW-1:0] ovf_result(input logic sgn, input logic [1:0] rm);
    case (rm)
      2'b00:   ovf_result = {sgn, INF_MAG};
      2'b01:   ovf_result = {sgn, MAX_MAG};
      2'b10:   ovf_result = sgn ? {1'b1, MAX_MAG} : {1'b0, INF_MAG};
      default: ovf_result = sgn ? {1'b1, INF_MAG} : {1'b0, MAX_MAG};
    endcase
  endfunction

  assign accept_c = bus.in_valid && (state_q == IDLE);

  logic [23:0]   m;
  logic          g, st, inc, ovf_rnd;
  logic [24:0]   mr;
  logic [EW-1:0] e_rnd;
  logic [7:0]    exp_fld;
  logic [22:0]   mant;
  logic [RW-1:0] rnd_res;

  // Rounding datapath, consumed only in ROUND.
  always_comb begin
    m  = f_q[46:23];
    g  = f_q[22];
    st = (|f_q[21:0]) | s_q;
    case (rmode_q)
      2'b00:   inc = g & (st | m[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = !sign_q & (g | st);
      default: inc = sign_q & (g | st);
    endcase
    mr      = {1'b0, m} + 25'(inc);
    e_rnd   = mr[24] ? e_q + EW'(1) : e_q;
    exp_fld = mr[24] ? e_rnd[7:0] : (mr[23] ? e_q[7:0] : 8'd0);
    mant    = mr[24] ? 23'd0 : mr[22:0];
    ovf_rnd = (e_rnd >= EW'(255));
    rnd_res = ovf_rnd ? ovf_result(sign_q, rmode_q) : {sign_q, exp_fld, mant};
  end

  // Next-state and output logic.
  always_comb begin
    state_n  = state_q;
    f_n      = f_q;
    e_n      = e_q;
    s_n      = s_q;
    first_n  = first_q;
    result_n = result_q;
    ovf_n    = ovf_q;
    unf_n    = unf_q;
    inx_n    = inx_q;
    zero_n   = zero_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          f_n     = bus.fract_in;
          e_n     = EW'(bus.exp_in);
          s_n     = 1'b0;
          first_n = 1'b1;
          state_n = NORM;
        end
      end
      NORM: begin
        first_n = 1'b0;
        if (first_q && (inf_q || exp_ovf_q == 2'b11 || exp_ovf_q == 2'b10 || f_q == '0)) begin
          state_n  = DONE;
          result_n = {sign_q, 31'd0};
          ovf_n    = 1'b0;
          unf_n    = 1'b0;
          inx_n    = 1'b0;
          zero_n   = 1'b0;
          if (inf_q) begin
            result_n = {sign_q, INF_MAG};
          end else if (exp_ovf_q == 2'b11) begin
            result_n = ovf_result(sign_q, rmode_q);
            ovf_n    = 1'b1;
            inx_n    = 1'b1;
          end else if (exp_ovf_q == 2'b10) begin
            unf_n  = 1'b1;
            inx_n  = 1'b1;
            zero_n = 1'b1;
          end else begin
            zero_n = 1'b1;
          end
        end else if (f_q[47]) begin
          f_n = f_q >> 1;
          s_n = s_q | f_q[0];
          e_n = e_q + EW'(1);
        end else if (e_q == '0) begin
          // Denormal range: shift right into the exponent-1 slot, keep sticky.
          f_n = f_q >> 1;
          s_n = s_q | f_q[0];
          e_n = EW'(1);
        end else if (!f_q[46] && (e_q > EW'(1))) begin
          f_n = f_q << 1;
          e_n = e_q - EW'(1);
        end else begin
          state_n = ROUND;
        end
      end
      ROUND: begin
        state_n  = DONE;
        result_n = rnd_res;
        ovf_n    = ovf_rnd;
        inx_n    = g | st;
        unf_n    = !ovf_rnd && (exp_fld == 8'd0) && (g | st);
        zero_n   = (rnd_res[30:0] == 31'd0);
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    out_valid_n = (state_n == DONE);
    in_ready_n  = (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      f_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      first_q     <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_n;
      f_q         <= f_n;
      e_q         <= e_n;
      s_q         <= s_n;
      first_q     <= first_n;
      result_q    <= result_n;
      ovf_q       <= ovf_n;
      unf_q       <= unf_n;
      inx_q       <= inx_n;
      zero_q      <= zero_n;
      out_valid_q <= out_valid_n;
      in_ready_q  <= in_ready_n;
    end
  end

  // Operation controls captured on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmode_q   <= 2'b00;
      exp_ovf_q <= 2'b00;
      sign_q    <= 1'b0;
      inf_q     <= 1'b0;
    end else if (accept_c) begin
      rmode_q   <= bus.rmode;
      exp_ovf_q <= bus.exp_ovf;
      sign_q    <= bus.sign_in;
      inf_q     <= bus.inf_in;
    end
  end

  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.inexact   = inx_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
endmodule
